// File: rtl/cam_pingpong_ctrl.sv
// Two-bank ping-pong ownership controller between a camera writer and a frame reader.
// Tracks per-bank state, assigns free banks to incoming frames, and drops frames with no free bank.
module cam_pingpong_ctrl #(
    parameter int DROP_W = 8
) (
    input  logic              iClk,
    input  logic              wRst,
    input  logic              wEnClk,
    input  logic              wFrStart,
    input  logic              wFrWrDone,
    input  logic              wRdDone,
    output logic              wWrEn,
    output logic              buf_sel_wr,
    output logic              buf0_full_wr,
    output logic              buf1_full_wr,
    output logic              wRdGo,
    output logic              buf_sel_rd,
    output logic              wFrDrop,
    output logic [DROP_W-1:0] wDropCnt
);

    typedef enum logic [1:0] {EMPTY, WRITING, FULL, READING} bank_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ACTIVE, W_SKIP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_LAUNCH, R_BUSY} rd_state_t;

    bank_state_t       bank_st [2];
    wr_state_t         wr_st;
    rd_state_t         rd_st;
    logic              last_wr;
    logic              oldest;     // bank that became FULL first while both are FULL
    logic [1:0]        full_q;

    logic              any_empty;
    logic              any_full;
    logic              wr_pick;
    logic              rd_pick;
    logic [DROP_W-1:0] drop_cnt_sat;

    assign any_empty    = (bank_st[0] == EMPTY) || (bank_st[1] == EMPTY);
    assign any_full     = (bank_st[0] == FULL)  || (bank_st[1] == FULL);
    assign drop_cnt_sat = (&wDropCnt) ? wDropCnt : wDropCnt + 1'b1;
    assign buf0_full_wr = full_q[0];
    assign buf1_full_wr = full_q[1];

    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        wr_pick = 1'b0;
        rd_pick = 1'b0;
        if (bank_st[0] == EMPTY && bank_st[1] == EMPTY)
            wr_pick = ~last_wr;
        else if (bank_st[1] == EMPTY)
            wr_pick = 1'b1;
        if (bank_st[0] == FULL && bank_st[1] == FULL)
            rd_pick = oldest;
        else if (bank_st[1] == FULL)
            rd_pick = 1'b1;
    end

    // Both FSMs share one block; they only ever touch distinct banks in the same cycle.
    always_ff @(posedge iClk) begin
        if (wRst) begin
            // NOTE: the two-entry bank table is control state, so it is reset like any other flop.
            bank_st[0] <= EMPTY;
            bank_st[1] <= EMPTY;
            wr_st      <= W_IDLE;
            rd_st      <= R_IDLE;
            last_wr    <= 1'b1;
            oldest     <= 1'b0;
            full_q     <= 2'b00;
            wWrEn      <= 1'b0;
            buf_sel_wr <= 1'b0;
            wRdGo      <= 1'b0;
            buf_sel_rd <= 1'b0;
            wFrDrop    <= 1'b0;
            wDropCnt   <= '0;
        end else if (wEnClk) begin
            // NOTE: non-blocking updates so every decision below sees the pre-edge bank state.
            wRdGo   <= 1'b0;
            wFrDrop <= 1'b0;

            unique case (rd_st)
                R_IDLE: if (any_full) begin
                    bank_st[rd_pick] <= READING;
                    buf_sel_rd       <= rd_pick;
                    rd_st            <= R_LAUNCH;
                end
                R_LAUNCH: begin
                    wRdGo <= 1'b1;
                    rd_st <= R_BUSY;
                end
                R_BUSY: if (wRdDone) begin
                    bank_st[buf_sel_rd] <= EMPTY;
                    full_q[buf_sel_rd]  <= 1'b0;
                    rd_st               <= R_IDLE;
                end
                default: rd_st <= R_IDLE;
            endcase

            unique case (wr_st)
                W_IDLE: if (wFrStart) begin
                    if (any_empty) begin
                        bank_st[wr_pick] <= WRITING;
                        buf_sel_wr       <= wr_pick;
                        wWrEn            <= 1'b1;
                        wr_st            <= W_ACTIVE;
                    end else begin
                        wFrDrop  <= 1'b1;
                        wDropCnt <= drop_cnt_sat;
                        wr_st    <= W_SKIP;
                    end
                end
                W_ACTIVE: if (wFrWrDone) begin
                    bank_st[buf_sel_wr] <= FULL;
                    full_q[buf_sel_wr]  <= 1'b1;
                    wWrEn               <= 1'b0;
                    last_wr             <= buf_sel_wr;
                    if (bank_st[~buf_sel_wr] != FULL)
                        oldest <= buf_sel_wr;
                    wr_st <= W_IDLE;
                end else if (wFrStart) begin
                    // Truncated frame: give the bank back and count it as dropped.
                    bank_st[buf_sel_wr] <= EMPTY;
                    wWrEn               <= 1'b0;
                    wFrDrop             <= 1'b1;
                    wDropCnt            <= drop_cnt_sat;
                    wr_st               <= W_IDLE;
                end
                W_SKIP: if (wFrWrDone) wr_st <= W_IDLE;
                default: wr_st <= W_IDLE;
            endcase
        end
    end

endmodule

// File: doc/cam_pingpong_ctrl.md
# cam_pingpong_ctrl

Ownership controller for the camera frame buffer's two banks (buf0, buf1). It sits between the camera write side and the buffer read side. It assigns a free bank to each incoming camera frame and publishes per-bank full flags. It launches the reader on the oldest full bank and returns banks to empty when the reader reports frame done. Frames that arrive with no free bank are dropped and counted, so the reader never sees a bank being overwritten mid-read.

## Interface
Parameters:
- DROP_W, 8, width of saturating dropped-frame counter

Ports:
- iClk  in  1  system clock
- wRst  in  1  reset; one clock (iClk), reset is synchronous and active-high
- wEnClk  in  1  clock enable; all state and outputs update only when high
- wFrStart  in  1  pulse; camera frame start (VSYNC edge), one enabled cycle
- wFrWrDone  in  1  pulse; writer has stored last pixel of current frame
- wRdDone  in  1  pulse; reader finished the bank granted by wRdGo (fr_done)
- wWrEn  out  1  level; writer may store pixels into bank buf_sel_wr
- buf_sel_wr  out  1  bank index for writer
- buf0_full_wr  out  1  level; buf0 holds a complete, unread frame or is being read
- buf1_full_wr  out  1  same for buf1
- wRdGo  out  1  pulse; start reader on bank buf_sel_rd
- buf_sel_rd  out  1  bank index for reader, stable from wRdGo until wRdDone
- wFrDrop  out  1  pulse; current camera frame discarded
- wDropCnt  out  DROP_W  saturating dropped-frame count

## Operation
- Per-bank state, 2 bits each: EMPTY, WRITING, FULL, READING.
- Writer FSM has three states: W_IDLE, W_ACTIVE, W_SKIP.
  - W_IDLE + wFrStart:
    - If any bank is EMPTY, mark it WRITING, set buf_sel_wr, assert wWrEn, and go to W_ACTIVE.
    - If both banks are EMPTY, choose ~last_wr (alternate banks; last_wr resets to 1, so the first frame goes to buf0).
    - If no bank is EMPTY, pulse wFrDrop, increment wDropCnt (saturating at all-ones), and go to W_SKIP.
  - W_ACTIVE + wFrWrDone: mark the bank FULL, clear wWrEn, record last_wr and the fill order, and go to W_IDLE.
  - W_ACTIVE + wFrStart (no done seen): this is a truncated frame. Return the bank to EMPTY, pulse wFrDrop, increment the counter, and go to W_IDLE. The new frame is not accepted on this edge.
  - W_SKIP + wFrWrDone: go to W_IDLE. W_SKIP + wFrStart: stay in W_SKIP.
- Reader FSM has three states: R_IDLE, R_LAUNCH, R_BUSY.
  - R_IDLE with at least one FULL bank: select the oldest FULL bank (fill-order bit), mark it READING, drive buf_sel_rd, and go to R_LAUNCH.
  - R_LAUNCH: pulse wRdGo for one enabled cycle, then go to R_BUSY.
  - R_BUSY + wRdDone: mark the bank EMPTY and go to R_IDLE.
  - wRdDone outside R_BUSY is ignored.
- bufN_full_wr = (state_N == FULL) || (state_N == READING). The level rises when the write completes and falls when the read completes, so it produces exactly one rising edge per frame for the reader's synchronizer.
- Simultaneous events in one enabled cycle:
  - wRdDone and wFrStart: the freed bank is not visible to the writer until the next cycle. The frame is dropped if the other bank is not EMPTY.
  - wFrWrDone and wRdDone: both updates apply; the banks are distinct by construction.
  - A bank completed in a cycle becomes eligible for reading on the next cycle.
- Invariant: a bank is never WRITING and READING at once; the writer never targets a FULL or READING bank.

## Timing
- All outputs are registered.
- Reset values (wRst high at an iClk edge): wWrEn=0, buf_sel_wr=0, buf0/1_full_wr=0, wRdGo=0, buf_sel_rd=0, wFrDrop=0, wDropCnt=0. Both banks are EMPTY, both FSMs are idle, last_wr=1.
- Reset overrides wEnClk and any in-flight frame. A frame in progress is abandoned and is not counted as a drop.
- While wEnClk=0, all state holds and pulses are not generated. Input pulses are sampled only on enabled cycles.
- Latencies are counted in enabled cycles:
  - wFrStart to wWrEn and buf_sel_wr valid: 1.
  - wFrWrDone to bufN_full_wr rising: 1.
  - Bank FULL to wRdGo: 2 (R_IDLE selects, then R_LAUNCH pulses), so wRdGo appears 3 enabled cycles after wFrWrDone.
  - wRdDone to bufN_full_wr falling and the bank EMPTY: 1.
- wFrDrop is a one-cycle pulse, 1 enabled cycle after the triggering input.

## Test plan
- Single frame:
  - Stimulus: reset, then wFrStart, then wFrWrDone 10 cycles later.
  - Response: buf_sel_wr=0; wWrEn high for 10 cycles; buf0_full_wr rises; wRdGo 2 cycles after the rise with buf_sel_rd=0.
  - Then wRdDone: buf0_full_wr falls the next cycle.
- Alternation:
  - Stimulus: three back-to-back frames with the reader completing each before the next write ends.
  - Response: buf_sel_wr sequence 0,1,0; wRdGo buf_sel_rd sequence 0,1,0; wDropCnt=0.
- Reader stalled:
  - Stimulus: write frames A and B, never assert wRdDone, then a third wFrStart.
  - Response: wFrDrop pulses and wDropCnt=1; wWrEn stays 0; wFrWrDone in W_SKIP is ignored for bank state.
  - Then wRdDone on A: buf0 becomes EMPTY, and the next wFrStart targets buf0. B (buf1) is read next as the oldest full bank.
- Truncated frame:
  - Stimulus: wFrStart, then a second wFrStart with no wFrWrDone.
  - Response: bank returns to EMPTY, wFrDrop pulses, bufN_full_wr never rises.
- Counter saturation and clock enable:
  - Stimulus: with DROP_W=2, force 5 drops.
  - Response: wDropCnt=3.
  - Stimulus: hold wEnClk=0 across a wFrWrDone pulse.
  - Response: no state change.
- Reset mid-operation:
  - Stimulus: assert wRst for one cycle while buf0 is READING and buf1 is WRITING.
  - Response: all outputs take their reset values the next cycle, wDropCnt=0, and the next frame goes to buf0.
